// File: rtl/i2s_rx_deserializer_pkg.sv
// Shared definitions for the I2S receive deserializer: FSM states, I2S polarity
// constants and the saturating bit-counter helper.
package i2s_rx_deserializer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic WS_LEFT    = 1'b0;
    localparam int   BITCNT_W   = 6;
    localparam int   BITCNT_MAX = 63;

    function automatic logic [BITCNT_W-1:0] bitcnt_inc(input logic [BITCNT_W-1:0] cnt);
        return (cnt == BITCNT_W'(BITCNT_MAX)) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/i2s_rx_deserializer_sync_edge_detect.sv
// Multi-stage synchroniser for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronised level.
module i2s_rx_deserializer_sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   q_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            q_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            q_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: oversamples bclk/ws/data in the sysclk domain, assembles left/right
// words MSB-first and presents complete stereo pairs; a silent bclk forces silence.
module i2s_rx_deserializer
    import i2s_rx_deserializer_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                           sysclk,
    input  logic                           reset_n,
    input  logic                           clkbd,
    input  logic                           wsbd,
    input  logic                           dabd,
    output logic signed [SAMPLE_WIDTH-1:0] audio_left,
    output logic signed [SAMPLE_WIDTH-1:0] audio_right,
    output logic                           sample_strobe,
    output logic                           locked,
    output logic                           frame_error
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic bclk_s, bclk_rise, bclk_fall;
    logic ws_s, ws_rise, ws_fall;
    logic da_s, da_rise, da_fall;
    logic unused_edges;

    i2s_rx_deserializer_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk  (sysclk),
        .rst_n(reset_n),
        .d    (clkbd),
        .q    (bclk_s),
        .rise (bclk_rise),
        .fall (bclk_fall)
    );

    i2s_rx_deserializer_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ws (
        .clk  (sysclk),
        .rst_n(reset_n),
        .d    (wsbd),
        .q    (ws_s),
        .rise (ws_rise),
        .fall (ws_fall)
    );

    i2s_rx_deserializer_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_da (
        .clk  (sysclk),
        .rst_n(reset_n),
        .d    (dabd),
        .q    (da_s),
        .rise (da_rise),
        .fall (da_fall)
    );

    assign unused_edges = bclk_s ^ bclk_fall ^ ws_rise ^ ws_fall ^ da_rise ^ da_fall;

    state_t                          state;
    logic                            ws_prev;
    logic [BITCNT_W-1:0]             bitcnt;
    logic [IDLE_W-1:0]               idle_cnt;
    logic                            have_l;
    logic [SAMPLE_WIDTH-1:0]         sr;
    logic [SAMPLE_WIDTH-1:0]         sr_next;
    logic signed [SAMPLE_WIDTH-1:0]  hold_l;
    logic                            ws_chg;

    logic signed [SAMPLE_WIDTH-1:0]  left_p0;
    logic signed [SAMPLE_WIDTH-1:0]  right_p0;
    logic                            vld_p0;

    // The word including the bit on this edge; bits past SAMPLE_WIDTH are dropped.
    always_comb begin
        ws_chg  = ws_s ^ ws_prev;
        sr_next = sr;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            if (int'(bitcnt) == SAMPLE_WIDTH - 1 - i) begin
                sr_next[i] = da_s;
            end
        end
    end

    // ---- stage p0: word assembly and pair capture on each bclk rise ----
    always_ff @(posedge sysclk) begin
        if (bclk_rise) begin
            sr <= ws_chg ? '0 : sr_next;
            if (ws_chg && state == S_RUN) begin
                if (ws_prev == WS_LEFT) begin
                    hold_l <= $signed(sr_next);
                end else begin
                    left_p0  <= hold_l;
                    right_p0 <= $signed(sr_next);
                end
            end
        end
    end

    // ---- stage p1: FSM, link supervision and registered outputs ----
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            ws_prev       <= WS_LEFT;
            bitcnt        <= '0;
            idle_cnt      <= '0;
            have_l        <= 1'b0;
            vld_p0        <= 1'b0;
            audio_left    <= '0;
            audio_right   <= '0;
            sample_strobe <= 1'b0;
            locked        <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            frame_error   <= 1'b0;
            vld_p0        <= 1'b0;

            if (vld_p0) begin
                audio_left    <= left_p0;
                audio_right   <= right_p0;
                sample_strobe <= 1'b1;
                locked        <= 1'b1;
            end

            if (bclk_rise) begin
                idle_cnt <= '0;
                ws_prev  <= ws_s;
                bitcnt   <= ws_chg ? '0 : bitcnt_inc(bitcnt);
                case (state)
                    S_IDLE: begin
                        state <= S_ALIGN;
                    end
                    S_ALIGN: begin
                        if (ws_chg) begin
                            state  <= S_RUN;
                            have_l <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (ws_chg) begin
                            if (ws_prev == WS_LEFT) begin
                                have_l <= 1'b1;
                            end else if (have_l) begin
                                vld_p0 <= 1'b1;
                                have_l <= 1'b0;
                            end
                        end else if (bitcnt == BITCNT_W'(BITCNT_MAX - 1)) begin
                            frame_error <= 1'b1;
                            locked      <= 1'b0;
                            have_l      <= 1'b0;
                            state       <= S_ALIGN;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES)) begin
                idle_cnt <= idle_cnt + 1'b1;
                // Dead link: force silence once, then sit saturated until bclk returns.
                if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    state       <= S_IDLE;
                    locked      <= 1'b0;
                    have_l      <= 1'b0;
                    audio_left  <= '0;
                    audio_right <= '0;
                end
            end
        end
    end

endmodule
